// File: rtl/param_select_pkg.sv
// -----------------------------------------------------------------------------
// param_select_pkg
// Shared definitions for the param_select_counter slice.
//   state_t   : controller state encoding (IDLE, RUN, DONE), 2 bits
//   DEF_WIDTH : default datapath width for x, n, m, n_in and capture_cnt
// -----------------------------------------------------------------------------
package param_select_pkg;

    localparam int DEF_WIDTH = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/psc_inv_checker.sv
// -----------------------------------------------------------------------------
// psc_inv_checker
// Watches the counter state every cycle and raises a sticky failure flag when
// either mined invariant is broken: x must never exceed n, and a finished run
// with a non-zero bound must leave m strictly below n.
// Built only when INVARIANT_CHECK_EN is defined.
// Ports:
//   clk      in  clock
//   rst      in  asynchronous active-high reset, clears the flag
//   state    in  current controller state
//   x, n, m  in  counter, latched bound, last captured value
//   inv_fail out sticky violation flag, set the cycle after a violation
// -----------------------------------------------------------------------------
module psc_inv_checker
    import param_select_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  state_t           state,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] m,
    output logic             inv_fail
);

    logic violation;
    logic fail_d;
    logic fail_q;

    // Evaluate both invariants and fold any violation into the sticky flag.
    always_comb begin
        violation = 1'b0;
        if (x > n) begin
            violation = 1'b1;
        end
        if ((state == DONE) && (n != '0) && (m >= n)) begin
            violation = 1'b1;
        end
        fail_d = fail_q | violation;
    end

    // Once set, the flag only clears on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_q <= 1'b0;
        end else begin
            fail_q <= fail_d;
        end
    end

    assign inv_fail = fail_q;

endmodule

// File: rtl/param_select_counter.sv
// -----------------------------------------------------------------------------
// param_select_counter
// Counts x from 0 up to a runtime bound n in increments of STEP, optionally
// capturing the pre-increment x into m whenever selector is high. Internal
// state is exposed so trace-based invariant mining can observe it.
// Optional feature: define INVARIANT_CHECK_EN to build psc_inv_checker and
// drive inv_fail from it; otherwise inv_fail is tied low.
// Parameters:
//   WIDTH : width of x, n, m, n_in, capture_cnt
//   STEP  : increment per RUN cycle, 1 .. 2**WIDTH-1
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   start        begin a run (only looked at in IDLE)
//   n_in         loop bound, latched on an accepted start
//   selector     capture request during RUN
//   busy         high while in RUN
//   done         one-cycle pulse in DONE
//   x, n, m      counter, latched bound, last captured x
//   capture_cnt  captures in the current run, saturating at all-ones
//   inv_fail     sticky invariant-violation flag
// -----------------------------------------------------------------------------
module param_select_counter
    import param_select_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    input  logic             selector,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] capture_cnt,
    output logic             inv_fail
);

    // One extra bit so the sum can be compared against n without wrapping.
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum;

    // Next-state and datapath updates; every register holds unless the
    // current state says otherwise.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        n_d     = n_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        sum     = {1'b0, x_q} + STEP_EXT;

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = n_in;
                    x_d     = '0;
                    m_d     = '0;
                    cnt_d   = '0;
                    state_d = (n_in == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (selector) begin
                    m_d = x_q;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                // Clamp to n on the final step so x never overshoots the bound.
                if (sum >= {1'b0, n_q}) begin
                    x_d     = n_q;
                    state_d = DONE;
                end else begin
                    x_d = sum[WIDTH-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            n_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            n_q     <= n_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign x           = x_q;
    assign n           = n_q;
    assign m           = m_q;
    assign capture_cnt = cnt_q;

`ifdef INVARIANT_CHECK_EN
    psc_inv_checker #(
        .WIDTH (WIDTH)
    ) u_inv_checker (
        .clk      (clk),
        .rst      (rst),
        .state    (state_q),
        .x        (x_q),
        .n        (n_q),
        .m        (m_q),
        .inv_fail (inv_fail)
    );
`else
    assign inv_fail = 1'b0;
`endif

endmodule

// File: tb/tb_param_select_counter.sv
// -----------------------------------------------------------------------------
// tb_param_select_counter
// Self-checking bench for param_select_counter. Three instances share the
// clock, reset, n_in and selector: STEP=1 (main), STEP=3 and STEP=1000.
// Expected run results are queued when a run is launched and compared when
// the main instance pulses done.
// -----------------------------------------------------------------------------
module tb_param_select_counter;

    localparam int W = 11;

`ifdef INVARIANT_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start, start3, startk;
    logic         selector;
    logic [W-1:0] n_in;

    logic         busy, done, inv_fail;
    logic [W-1:0] x, n, m, capture_cnt;
    logic         busy3, done3, inv_fail3;
    logic [W-1:0] x3, n3, m3, cnt3;
    logic         busyk, donek, inv_failk;
    logic [W-1:0] xk, nk, mk, cntk;

    typedef struct {
        logic [W-1:0] n;
        logic [W-1:0] x;
        logic [W-1:0] m;
        logic [W-1:0] cnt;
    } sb_t;

    typedef struct {
        logic [W-1:0] n_in;
        int           mode;
        int           exp_busy;
        logic [W-1:0] exp_x;
        logic [W-1:0] exp_m;
        logic [W-1:0] exp_cnt;
    } vec_t;

    sb_t sbq[$];
    int  checkCount = 0;
    int  passCount  = 0;
    bit  monitorOn  = 1'b0;

    always #5 clk = ~clk;

    param_select_counter #(.WIDTH(W), .STEP(1)) dut (
        .clk(clk), .rst(rst), .start(start), .n_in(n_in), .selector(selector),
        .busy(busy), .done(done), .x(x), .n(n), .m(m),
        .capture_cnt(capture_cnt), .inv_fail(inv_fail)
    );

    param_select_counter #(.WIDTH(W), .STEP(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .n_in(n_in), .selector(selector),
        .busy(busy3), .done(done3), .x(x3), .n(n3), .m(m3),
        .capture_cnt(cnt3), .inv_fail(inv_fail3)
    );

    param_select_counter #(.WIDTH(W), .STEP(1000)) dutk (
        .clk(clk), .rst(rst), .start(startk), .n_in(n_in), .selector(selector),
        .busy(busyk), .done(donek), .x(xk), .n(nk), .m(mk),
        .capture_cnt(cntk), .inv_fail(inv_failk)
    );

    // Single comparison point: every check steps checkCount and passCount.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [2047:0] buildBits(input int mode);
        logic [2047:0] b;
        b = '0;
        for (int i = 0; i < 2048; i++) begin
            case (mode)
                1:       b[i] = 1'b1;
                2:       b[i] = ((i % 2) == 0);
                default: b[i] = 1'b0;
            endcase
        end
        return b;
    endfunction

    function automatic longint allOutputs();
        return longint'({x, n, m, capture_cnt, busy, done, inv_fail});
    endfunction

    // Scoreboard: compare each done pulse of the main instance against the
    // oldest queued expectation.
    sb_t e;
    always @(negedge clk) begin
        if (monitorOn && !rst && done) begin
            if (sbq.size() == 0) begin
                checkOutput("sb_unexpected_done", 1, 0);
            end else begin
                e = sbq.pop_front();
                checkOutput("sb_x", x, e.x);
                checkOutput("sb_n", n, e.n);
                checkOutput("sb_m", m, e.m);
                checkOutput("sb_cnt", capture_cnt, e.cnt);
                if (e.n != '0) begin
                    checkOutput("sb_m_lt_n", longint'(m < n), 1);
                end
            end
        end
    end

    // Launch one run on the main instance from IDLE, drive selector bits per
    // RUN cycle (bit i is seen while x==i), and check latency and busy length.
    task automatic applyStimulus(input logic [W-1:0] nv, input logic [2047:0] bits,
                                 input logic [W-1:0] ex, input logic [W-1:0] em,
                                 input logic [W-1:0] ecnt, input int expBusy,
                                 input string tag);
        int  busyCount;
        int  idx;
        int  cyc;
        bit  seen;
        sb_t s;
        s.n = nv; s.x = ex; s.m = em; s.cnt = ecnt;
        sbq.push_back(s);
        start    = 1'b1;
        n_in     = nv;
        selector = bits[0];
        @(negedge clk);
        start     = 1'b0;
        busyCount = 0;
        idx       = 0;
        cyc       = 1;
        seen      = 1'b0;
        while (!seen && cyc < 3000) begin
            if (busy) begin
                busyCount++;
                selector = bits[idx];
                idx++;
            end
            if (done) begin
                seen = 1'b1;
                checkOutput({tag, "_done_cycle"}, cyc, expBusy + 1);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) begin
            checkOutput({tag, "_done_timeout"}, 0, 1);
        end
        checkOutput({tag, "_busy_cycles"}, busyCount, expBusy);
        selector = 1'b0;
        @(negedge clk);
    endtask

    vec_t         vecs[6];
    logic [W-1:0] trace3[5];
    logic [W-1:0] tracek[4];

    initial begin
        logic [2047:0] rb;
        logic [W-1:0]  rn, rm, rc;
        int            cyc;
        time           tEnd;

        vecs[0] = '{n_in: 11'd5,    mode: 1, exp_busy: 5,    exp_x: 11'd5,    exp_m: 11'd4,    exp_cnt: 11'd5};
        vecs[1] = '{n_in: 11'd0,    mode: 1, exp_busy: 0,    exp_x: 11'd0,    exp_m: 11'd0,    exp_cnt: 11'd0};
        vecs[2] = '{n_in: 11'd7,    mode: 0, exp_busy: 7,    exp_x: 11'd7,    exp_m: 11'd0,    exp_cnt: 11'd0};
        vecs[3] = '{n_in: 11'd1,    mode: 1, exp_busy: 1,    exp_x: 11'd1,    exp_m: 11'd0,    exp_cnt: 11'd1};
        vecs[4] = '{n_in: 11'd6,    mode: 2, exp_busy: 6,    exp_x: 11'd6,    exp_m: 11'd4,    exp_cnt: 11'd3};
        vecs[5] = '{n_in: 11'd2047, mode: 1, exp_busy: 2047, exp_x: 11'd2047, exp_m: 11'd2046, exp_cnt: 11'd2047};
        trace3 = '{11'd0, 11'd3, 11'd6, 11'd9, 11'd10};
        tracek = '{11'd0, 11'd1000, 11'd2000, 11'd2047};

        rst = 1'b0; start = 1'b0; start3 = 1'b0; startk = 1'b0;
        selector = 1'b0; n_in = '0;
        #1 rst = 1'b1;

        // Reset then idle.
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", allOutputs(), 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("idle_outputs_%0d", i), allOutputs(), 0);
        end

        // Table-driven runs on the STEP=1 instance.
        monitorOn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].n_in, buildBits(vecs[i].mode), vecs[i].exp_x,
                          vecs[i].exp_m, vecs[i].exp_cnt, vecs[i].exp_busy,
                          $sformatf("vec%0d", i));
        end

        // STEP=3, n=10: x walks 0,3,6,9 then clamps to 10.
        selector = 1'b1;
        n_in     = 11'd10;
        start3   = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("s3_x%0d", i), x3, trace3[i]);
            checkOutput($sformatf("s3_busy%0d", i), busy3, longint'(i < 4));
            checkOutput($sformatf("s3_done%0d", i), done3, longint'(i == 4));
            @(negedge clk);
        end
        checkOutput("s3_m", m3, 9);
        checkOutput("s3_cnt", cnt3, 4);
        checkOutput("s3_x_hold", x3, 10);

        // STEP=1000, n=2047: no wrap past the top of the range.
        n_in   = 11'd2047;
        startk = 1'b1;
        @(negedge clk);
        startk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("sk_x%0d", i), xk, tracek[i]);
            checkOutput($sformatf("sk_busy%0d", i), busyk, longint'(i < 3));
            checkOutput($sformatf("sk_done%0d", i), donek, longint'(i == 3));
            @(negedge clk);
        end
        checkOutput("sk_m", mk, 2000);
        checkOutput("sk_cnt", cntk, 3);
        selector = 1'b0;

        // Asynchronous reset between edges at RUN cycle 40 of a 100 run.
        selector = 1'b1;
        n_in     = 11'd100;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        checkOutput("mid_busy", busy, 1);
        checkOutput("mid_x", x, 39);
        checkOutput("mid_cnt", capture_cnt, 39);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_outputs", allOutputs(), 0);
        checkOutput("mid_rst_state", longint'(dut.state_q), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("mid_rst_no_done%0d", i), done, 0);
        end
        rst      = 1'b0;
        selector = 1'b0;
        @(negedge clk);
        applyStimulus(11'd3, buildBits(1), 11'd3, 11'd2, 11'd3, 3, "post_rst");

        // Back-to-back random runs with random selector for ~1000 cycles.
        tEnd = $time + 10000;
        while ($time < tEnd) begin
            rn = W'($urandom_range(0, 30));
            for (int w = 0; w < 64; w++) begin
                rb[w*32 +: 32] = $urandom();
            end
            rm = '0;
            rc = '0;
            for (int i = 0; i < int'(rn); i++) begin
                if (rb[i]) begin
                    rm = W'(i);
                    rc = rc + W'(1);
                end
            end
            applyStimulus(rn, rb, rn, rm, rc, int'(rn), "rand");
        end
        checkOutput("rand_inv_fail", inv_fail, 0);
        checkOutput("rand_sb_drained", sbq.size(), 0);

        // Forced m==n at DONE must trip the checker and stay set until reset.
        monitorOn = 1'b0;
        n_in      = 11'd5;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        force dut.m_q = 11'd5;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("force_done_seen", done, 1);
        checkOutput("force_inv_before", inv_fail, 0);
        @(negedge clk);
        checkOutput("force_inv_set", inv_fail, longint'(CHK_EN));
        release dut.m_q;
        repeat (3) @(negedge clk);
        checkOutput("force_inv_sticky", inv_fail, longint'(CHK_EN));
        rst = 1'b1;
        #1;
        checkOutput("force_inv_cleared", inv_fail, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
